// File: rtl/load_store_unit.sv
// Load/store unit: the initiator side of a byte-addressed data memory.
// It accepts one request at a time, checks it for legality, and drives the
// memory pins. Stores narrower than a word become read-modify-write, because
// the memory commits a whole word on each rising edge of its enable.
module load_store_unit #(
  parameter int WORD_SIZE = 32,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [WORD_SIZE-1:0] req_base_i,
  input  logic [WORD_SIZE-1:0] req_offset_i,
  input  logic [WORD_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [WORD_SIZE-1:0] rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic                 en_mem_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic [WORD_SIZE-1:0] addr_base_o,
  output logic [WORD_SIZE-1:0] addr_offset_o,
  output logic [WORD_SIZE-1:0] val_o,
  input  logic [WORD_SIZE-1:0] val_i
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WSET,
    ST_WPULSE,
    ST_RESP
  } state_t;

  localparam logic [WORD_SIZE-1:0] LastWord = WORD_SIZE'(MEM_SIZE - 4);

  state_t               r_state;
  logic                 r_write;
  logic [2:0]           r_funct3;
  logic [1:0]           r_lane;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 r_enMem;
  logic                 r_memRead;
  logic                 r_memWrite;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_val;
  logic                 r_rspValid;
  logic                 r_rspError;
  logic [WORD_SIZE-1:0] r_rspRdata;

  logic [WORD_SIZE-1:0] w_ea;
  logic [WORD_SIZE-1:0] w_aligned;
  logic                 w_funct3Bad;
  logic                 w_misaligned;
  logic                 w_outOfRange;
  logic                 w_error;
  logic                 w_rmw;
  logic [4:0]           w_shift;
  logic [WORD_SIZE-1:0] w_lane;
  logic [WORD_SIZE-1:0] w_loadData;
  logic [WORD_SIZE-1:0] w_mask;
  logic [WORD_SIZE-1:0] w_merged;

  // Decode the incoming request: effective address and every rejection reason.
  always_comb begin
    w_ea      = req_base_i + req_offset_i;
    w_aligned = {w_ea[WORD_SIZE-1:2], 2'b00};
    if (req_write_i) begin
      w_funct3Bad = (req_funct3_i > 3'd2);
    end else begin
      w_funct3Bad = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11);
    end
    w_misaligned = ((req_funct3_i[1:0] == 2'b01) && w_ea[0]) ||
                   ((req_funct3_i[1:0] == 2'b10) && (w_ea[1:0] != 2'b00));
    w_outOfRange = (w_aligned > LastWord);
    w_error      = w_funct3Bad || w_misaligned || w_outOfRange;
    w_rmw        = req_write_i && (req_funct3_i[1:0] != 2'b10);
  end

  // Lane extraction with extension for loads, and lane merge for narrow stores.
  always_comb begin
    w_shift = {r_lane, 3'b000};
    w_lane  = val_i >> w_shift;
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_loadData = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_loadData = {24'd0, w_lane[7:0]};
      3'b101:  w_loadData = {16'd0, w_lane[15:0]};
      default: w_loadData = val_i;
    endcase
    if (r_funct3[1:0] == 2'b00) begin
      w_mask = 32'h0000_00FF << w_shift;
    end else begin
      w_mask = 32'h0000_FFFF << w_shift;
    end
    w_merged = (val_i & ~w_mask) | ((r_wdata << w_shift) & w_mask);
  end

  // Request sequencer: every memory and response pin is a register set here.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ST_IDLE;
      r_write    <= 1'b0;
      r_funct3   <= 3'd0;
      r_lane     <= 2'd0;
      r_wdata    <= '0;
      r_enMem    <= 1'b0;
      r_memRead  <= 1'b0;
      r_memWrite <= 1'b0;
      r_addr     <= '0;
      r_val      <= '0;
      r_rspValid <= 1'b0;
      r_rspError <= 1'b0;
      r_rspRdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_write  <= req_write_i;
            r_funct3 <= req_funct3_i;
            r_lane   <= w_ea[1:0];
            r_wdata  <= req_wdata_i;
            if (w_error) begin
              r_rspValid <= 1'b1;
              r_rspError <= 1'b1;
              r_rspRdata <= '0;
              r_state    <= ST_RESP;
            end else if (req_write_i && !w_rmw) begin
              r_addr     <= w_aligned;
              r_val      <= req_wdata_i;
              r_memWrite <= 1'b1;
              r_state    <= ST_WSET;
            end else begin
              r_addr    <= w_aligned;
              r_enMem   <= 1'b1;
              r_memRead <= 1'b1;
              r_state   <= ST_RD;
            end
          end
        end
        ST_RD: begin
          r_enMem   <= 1'b0;
          r_memRead <= 1'b0;
          if (r_write) begin
            r_val      <= w_merged;
            r_memWrite <= 1'b1;
            r_state    <= ST_WSET;
          end else begin
            r_addr     <= '0;
            r_rspValid <= 1'b1;
            r_rspError <= 1'b0;
            r_rspRdata <= w_loadData;
            r_state    <= ST_RESP;
          end
        end
        ST_WSET: begin
          r_enMem <= 1'b1;
          r_state <= ST_WPULSE;
        end
        ST_WPULSE: begin
          r_enMem    <= 1'b0;
          r_memWrite <= 1'b0;
          r_addr     <= '0;
          r_val      <= '0;
          r_rspValid <= 1'b1;
          r_rspError <= 1'b0;
          r_rspRdata <= '0;
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          r_rspValid <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (r_state == ST_IDLE);
  assign rsp_valid_o   = r_rspValid;
  assign rsp_rdata_o   = r_rspRdata;
  assign rsp_error_o   = r_rspError;
  assign en_mem_o      = r_enMem;
  assign mem_read_o    = r_memRead;
  assign mem_write_o   = r_memWrite;
  assign addr_base_o   = r_addr;
  assign addr_offset_o = '0;
  assign val_o         = r_val;

endmodule
